// File: rtl/chan_mux_scan_pkg.sv
// Shared constants and helpers for the channel mux/scan block.
// Holds the mode encoding and a constant-foldable ceil(log2) used for width derivation.
package chan_mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2; returns 0 for values <= 1, so callers clamp to a minimum width of 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts enabled cycles 0..DWELL-1 and flags the last one.
// clr (sampled with en) restarts the count so a new scan gets a full dwell.
module dwell_counter
  import chan_mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (clog2(DWELL) > 1) ? clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (clr || count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/chan_mux_scan.sv
// Registered channel multiplexer with manual select and timed auto-scan.
// ch and dout load together, so ch always names the channel that produced dout.
module chan_mux_scan
  import chan_mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 3,
  parameter  int DWELL    = 4,
  localparam int SEL_W    = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          ch,
  output logic                      dout_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic             scan_mode;
  logic             tick;
  logic [SEL_W-1:0] ch_next;
  logic             wrap_next;
  logic             sel_err_next;

  assign scan_mode = (mode == MODE_SCAN);

  // Manual mode holds the counter clear, so a switch to scan dwells fully on the current channel.
  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (!scan_mode),
    .tick (tick)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ch_next      = ch;
    wrap_next    = 1'b0;
    sel_err_next = 1'b0;
    if (scan_mode) begin
      if (tick) begin
        if (ch == LAST_CH) begin
          ch_next   = '0;
          wrap_next = 1'b1;
        end else begin
          ch_next = ch + SEL_W'(1);
        end
      end
    end else if (int'(sel) < CHANNELS) begin
      ch_next = sel;
    end else begin
      sel_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      dout_valid <= en;
      wrap       <= en && wrap_next;
      sel_err    <= en && sel_err_next;
      if (en) begin
        ch   <= ch_next;
        dout <= din[int'(ch_next)*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Self-checking bench for chan_mux_scan (WIDTH=4, CHANNELS=3, DWELL=2).
// A cycle-level model is compared every cycle; directed literal checks pin the model.
module tb_chan_mux_scan;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int DW = 2;

  logic          clk;
  logic          reset;
  logic [CH*W-1:0] din;
  logic [1:0]    sel;
  logic          mode;
  logic          en;
  logic [W-1:0]  dout;
  logic [1:0]    ch;
  logic          dout_valid;
  logic          wrap;
  logic          sel_err;

  int checks;
  int failures;

  chan_mux_scan #(
    .WIDTH   (W),
    .CHANNELS(CH),
    .DWELL   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .dout      (dout),
    .ch        (ch),
    .dout_valid(dout_valid),
    .wrap      (wrap),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_elapsed counts enabled scan cycles spent on the current channel.
  bit live;
  int m_ch, m_elapsed, m_dout;
  bit m_valid, m_wrap, m_err;

  always @(posedge clk) begin
    if (reset) begin
      live = 1'b1;
      m_ch = 0; m_elapsed = 0; m_dout = 0;
      m_valid = 0; m_wrap = 0; m_err = 0;
    end else if (live) begin
      m_valid = en;
      m_wrap  = 0;
      m_err   = 0;
      if (en) begin
        if (mode == 1'b0) begin
          m_elapsed = 0;
          if (sel < CH) m_ch = sel;
          else m_err = 1;
        end else begin
          m_elapsed++;
          if (m_elapsed == DW) begin
            m_elapsed = 0;
            m_wrap = (m_ch == CH - 1);
            m_ch = (m_ch + 1) % CH;
          end
        end
        m_dout = int'((din >> (m_ch * W)) & 12'hF);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_ch", 32'(ch), 32'(m_ch));
      check("model_dout", 32'(dout), 32'(m_dout));
      check("model_valid", 32'(dout_valid), 32'(m_valid));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_sel_err", 32'(sel_err), 32'(m_err));
      check("wrap_err_exclusive", 32'(wrap && sel_err), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int e_ch, input int e_dout,
                            input bit e_valid, input bit e_wrap, input bit e_err);
    check({name, ".ch"}, 32'(ch), 32'(e_ch));
    check({name, ".dout"}, 32'(dout), 32'(e_dout));
    check({name, ".valid"}, 32'(dout_valid), 32'(e_valid));
    check({name, ".wrap"}, 32'(wrap), 32'(e_wrap));
    check({name, ".sel_err"}, 32'(sel_err), 32'(e_err));
  endtask

  int scan_seq [6];
  int ch_data [3];

  initial begin
    checks = 0;
    failures = 0;
    scan_seq = '{0, 1, 1, 2, 2, 0};
    ch_data  = '{'hA, 'hB, 'hC};

    reset = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; din = 12'hCBA;
    cyc(2);
    expect_out("reset_hold", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1);
    expect_out("idle_after_reset", 0, 0, 0, 0, 0);

    // Manual selection and out-of-range select.
    en = 1'b1; sel = 2'd2;
    cyc(1);
    expect_out("manual_sel2", 2, 'hC, 1, 0, 0);
    sel = 2'd3;
    cyc(1);
    expect_out("manual_bad_sel", 2, 'hC, 1, 0, 1);
    en = 1'b0;
    cyc(1);
    expect_out("bad_sel_cleared", 2, 'hC, 0, 0, 0);
    en = 1'b1; sel = 2'd0;
    cyc(1);
    expect_out("manual_sel0_no_wrap", 0, 'hA, 1, 0, 0);

    // Scan from channel 0: one full lap.
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      expect_out($sformatf("scan_lap%0d", i), scan_seq[i], ch_data[scan_seq[i]], 1, i == 5, 0);
    end

    // Freeze mid-dwell, then resume.
    cyc(1);
    expect_out("scan_mid_dwell", 0, 'hA, 1, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      expect_out($sformatf("frozen%0d", i), 0, 'hA, 0, 0, 0);
    end
    en = 1'b1;
    cyc(1);
    expect_out("resume_advance", 1, 'hB, 1, 0, 0);

    // Advance to channel 2 mid-dwell, then reset.
    cyc(1);
    expect_out("to_ch2_a", 1, 'hB, 1, 0, 0);
    cyc(1);
    expect_out("to_ch2_b", 2, 'hC, 1, 0, 0);
    cyc(1);
    expect_out("to_ch2_c", 2, 'hC, 1, 0, 0);
    reset = 1'b1;
    cyc(1);
    expect_out("scan_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1);
    expect_out("post_reset_dwell0", 0, 'hA, 1, 0, 0);
    cyc(1);
    expect_out("post_reset_dwell1", 1, 'hB, 1, 0, 0);

    // Manual ch1 then scan with din B changed.
    mode = 1'b0; sel = 2'd1;
    cyc(1);
    expect_out("manual_ch1", 1, 'hB, 1, 0, 0);
    mode = 1'b1; din = 12'hC5A;
    cyc(1);
    expect_out("scan_hold_new_data", 1, 'h5, 1, 0, 0);
    cyc(1);
    expect_out("scan_advance_ch2", 2, 'hC, 1, 0, 0);

    en = 1'b0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_mux_scan.md
CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data width per channel, >= 1.
REQ-002 The block SHALL have parameter CHANNELS, default 3: number of input channels, 2..16.
REQ-003 The block SHALL have parameter DWELL, default 4: cycles per channel in scan mode, 1..255.
REQ-004 The block SHALL have derived localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-005 The block SHALL have one clock and synchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port din, input, CHANNELS*WIDTH, packed channels; channel k = din[k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SEL_W, manual channel select.
REQ-009 The block SHALL have port mode, input, 1: 0 = manual, 1 = auto-scan.
REQ-010 The block SHALL have port en, input, 1, clock enable for all state.
REQ-011 The block SHALL have port dout, output, WIDTH, registered selected data.
REQ-012 The block SHALL have port ch, output, SEL_W, channel index currently driving dout.
REQ-013 The block SHALL have port dout_valid, output, 1: high the cycle after an enabled edge.
REQ-014 The block SHALL have port wrap, output, 1: one-cycle pulse when scan advances CHANNELS-1 -> 0.
REQ-015 The block SHALL have port sel_err, output, 1: one-cycle pulse when manual sel >= CHANNELS.

Function
REQ-016 ch_next SHALL be the channel loaded at an enabled edge; on that same edge dout <= din slice[ch_next] and ch <= ch_next, so ch and dout always correspond. Latency din -> dout is 1 cycle.
REQ-017 Manual mode (mode=0, en=1): sel < CHANNELS gives ch_next = sel. sel >= CHANNELS gives ch_next = ch (hold) with sel_err = 1 for one cycle.
REQ-018 Scan mode (mode=1, en=1): dwell counter increments 0..DWELL-1. At count DWELL-1, ch_next = (ch == CHANNELS-1) ? 0 : ch+1 and the counter returns to 0; otherwise ch_next = ch.
REQ-019 wrap SHALL be 1 for exactly the cycle following the edge where ch goes CHANNELS-1 -> 0 in scan mode; manual selection of 0 never asserts wrap.
REQ-020 With DWELL=1, ch SHALL advance on every enabled edge.
REQ-021 Mode change manual -> scan: scan starts from the current ch, dwell counter cleared to 0 on the first scan edge boundary (first advance after DWELL enabled cycles).
REQ-022 Mode change scan -> manual: dwell counter cleared; ch_next = sel per REQ-017.
REQ-023 With en=0: ch, dout, dwell counter hold; dout_valid, wrap and sel_err = 0 next cycle.
REQ-024 Data in dout SHALL be refreshed every enabled edge even when ch is unchanged, tracking din.
REQ-025 wrap and sel_err SHALL never be asserted simultaneously; both outputs SHALL be registered.

Reset
REQ-026 On reset=1 at a rising edge: ch=0, dout=0, dwell counter=0, dout_valid=0, wrap=0, sel_err=0. Reset overrides en and mode.
REQ-027 Reset mid-dwell or mid-wrap SHALL discard progress; the first enabled edge after reset behaves as from ch=0, count=0.

Structure
REQ-028 A shared package SHALL hold MODE_MANUAL=0 and MODE_SCAN=1 constants, plus a clog2 helper function.
REQ-029 One sub-module, dwell_counter, SHALL be used: parameter DWELL; inputs clk, reset, en, clr; output tick (count == DWELL-1 and en).
REQ-030 Slice selection SHALL be an indexed part-select, not a per-channel case, so CHANNELS scales without edits.

Verification (WIDTH=4, CHANNELS=3, DWELL=2; din = {C:0xC, B:0xB, A:0xA})
REQ-031 Reset asserted 2 cycles, then released with en=0 -> dout=0, ch=0, dout_valid=0.
REQ-032 Manual, en=1, sel=2 -> next cycle dout=0xC, ch=2, dout_valid=1. Then sel=3 -> ch stays 2, sel_err pulses 1 cycle.
REQ-033 Scan from ch=0, en=1 for 6 cycles -> ch sequence 0,0,1,1,2,2,0; wrap=1 only on the cycle ch returns to 0.
REQ-034 Scan with en low for 3 cycles mid-dwell -> ch, dout and count frozen; dout_valid=0; sequence resumes unchanged.
REQ-035 Reset pulse while ch=2 in scan -> next cycle ch=0, dout=0, wrap=0; scan restarts with full DWELL on ch 0.
REQ-036 Manual ch=1, switch to scan -> ch stays 1 for 2 enabled cycles, then 2; din[B] changed to 0x5 meanwhile -> dout=0x5 one cycle later.
